mips_to_riscv_xlate_q: RTL and testbench
========================================

MIPS_TO_RISCV_XLATE_Q -- requirements
Module: mips_to_riscv_xlate_q

Interface
REQ-001 SHALL have parameter OUT_DEPTH, default 4, output queue entries, power of 2, >=2.
REQ-002 SHALL have parameter BR_ADJ, default 4, byte adjustment subtracted from branch offsets.
REQ-003 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-004 SHALL have port pipe_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mips_instruction  in  32  MIPS word.
REQ-006 SHALL have port mips_instr_valid  in  1  input word valid.
REQ-007 SHALL have port mips_instr_error  in  1  fetch error tagged on input word.
REQ-008 SHALL have port translator_ready  out  1  input accepted when valid&&ready.
REQ-009 SHALL have port flush  in  1  synchronous discard of all pending work.
REQ-010 SHALL have port riscv_instruction  out  32  queue head instruction.
REQ-011 SHALL have port riscv_instr_valid  out  1  queue non-empty.
REQ-012 SHALL have port riscv_instr_error  out  1  queue head error flag.
REQ-013 SHALL have port riscv_instr_accepted  in  1  consumer pops head when valid&&accepted.
REQ-014 SHALL have port q_level  out  $clog2(OUT_DEPTH)+1  current queue occupancy.

Function
REQ-015 SHALL store {error, instr[31:0]} entries in a circular queue; push and pop in the same cycle both take effect; wrap-around by pointer modulo OUT_DEPTH.
REQ-016 SHALL drive translator_ready = !flush && (OUT_DEPTH - q_level) >= 2, registered-occupancy based, so up to two pushes per accept never overflow.
REQ-017 SHALL push entries in the accept cycle; entries are visible at the head earliest one cycle later (latency 1).
REQ-018 SHALL run input FSM states IDLE, HOLD_BR (branch/JR stashed, waiting for delay slot), HOLD_LUI (LUI stashed, waiting for fusion candidate).
REQ-019 SHALL, on BEQ, BNE or JR accepted in IDLE, stash it and enter HOLD_BR with no push.
REQ-020 SHALL, in HOLD_BR, on next accept push translated slot then translated branch (two entries), return to IDLE; a branch/JR in the slot is pushed as error entry.
REQ-021 SHALL translate: ADDU->ADD, SLTU->SLTU, OR->OR, SLL->SLLI, JR->JALR x0,rs,0, ADDIU->ADDI, LUI->LUI imm20={imm16,4'b0}, ORI->ORI, SW->SW, BEQ/BNE->BEQ/BNE with offset=(imm<<2)-BR_ADJ.
REQ-022 SHALL flag error with instr 32'h0 for: unknown opcode/funct; ADDIU or SW imm outside signed 12-bit; ORI imm[15:12]!=0; branch offset outside signed 13-bit.
REQ-023 SHALL push any word accepted with mips_instr_error=1 as error entry with instr 32'h0, keeping FSM sequencing (it may fill a delay slot).
REQ-024 SHALL, on flush, empty the queue and return to IDLE next cycle, discarding stashed words; flush concurrent with accept drops the word.

Reset
REQ-025 SHALL, while pipe_rst_n=0, force FSM=IDLE, pointers=0, q_level=0, riscv_instr_valid=0, riscv_instr_error=0, translator_ready=0.
REQ-026 SHALL, on reset mid-operation, discard stashed and queued instructions without output.

Configuration
REQ-027 SHALL compile LUI+ORI fusion only when macro MIPS_XLATE_LUI_ORI_FUSE_EN is defined; without it LUI pushes immediately from IDLE and HOLD_LUI is absent.
REQ-028 SHALL, with fusion, stash LUI in IDLE->HOLD_LUI; next ORI with rs==rt==LUI.rt pushes LUI imm20=C[31:12]+C[11] and ADDI imm=C[11:0], C={lui.imm,ori.imm}, then IDLE.
REQ-029 SHALL, with fusion, on a non-matching word in HOLD_LUI push plain LUI then process the word as if in IDLE (branch->HOLD_BR, LUI->restash, else push).

Structure
REQ-030 SHALL place MIPS opcode/funct constants, mips_i_type_t/mips_r_type_t typedefs and queue entry typedef in shared package mips_xlate_pkg.
REQ-031 SHALL implement the queue as sub-module mips_xlate_outq.

Verification
REQ-032 SHALL cover: ADDU 0x00851021 -> one entry 0x00520133, error=0, valid one cycle after accept.
REQ-033 SHALL cover: BEQ 0x10850003 then ADDU 0x00851021 -> 0x00520133 then 0x00520463.
REQ-034 SHALL cover with fusion: 0x3C081234, 0x35085678 -> 0x12345437, 0x67840413; 0x3C081234, 0x35080800 -> 0x12341437, 0x80040413.
REQ-035 SHALL cover without fusion: 0x3C081234 -> 0x12340437; 0x35085678 -> error entry, instr 0.
REQ-036 SHALL cover OUT_DEPTH=4, accepted held 0: three single pushes -> q_level=3, translator_ready=0; one pop -> ready=1.
REQ-037 SHALL cover: BEQ accepted, flush next cycle -> queue empty, IDLE, no branch output.

Source files
------------

// File: rtl/mips_xlate_pkg.sv
// ---------------------------------------------------------------------------
// mips_xlate_pkg
// Shared definitions for the MIPS -> RISC-V translating queue:
//   - MIPS opcode / funct constants and RISC-V major opcodes
//   - mips_i_type_t / mips_r_type_t field views of a MIPS word
//   - xq_entry_t output queue entry {error, instr}
//   - input FSM state enum
//   - single-word translation helpers
// Optional feature macro: MIPS_XLATE_LUI_ORI_FUSE_EN (adds HOLD_LUI state).
// ---------------------------------------------------------------------------
package mips_xlate_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] FN_SLL     = 6'h00;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_OR      = 6'h25;
   localparam logic [5:0] FN_SLTU    = 6'h2B;

   localparam logic [6:0] RV_OP      = 7'b0110011;
   localparam logic [6:0] RV_OP_IMM  = 7'b0010011;
   localparam logic [6:0] RV_LUI     = 7'b0110111;
   localparam logic [6:0] RV_STORE   = 7'b0100011;
   localparam logic [6:0] RV_BRANCH  = 7'b1100011;
   localparam logic [6:0] RV_JALR    = 7'b1100111;

   localparam int ENTRY_W = 33;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [15:0] imm;
   } mips_i_type_t;

   typedef struct packed {
      logic [5:0] opcode;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [4:0] shamt;
      logic [5:0] funct;
   } mips_r_type_t;

   typedef struct packed {
      logic        error;
      logic [31:0] instr;
   } xq_entry_t;

   localparam xq_entry_t ERR_ENTRY = '{error: 1'b1, instr: 32'h0};

   typedef enum logic [1:0] {
      IDLE,
      HOLD_BR
`ifdef MIPS_XLATE_LUI_ORI_FUSE_EN
      ,
      HOLD_LUI
`endif
   } xlate_state_t;

   function automatic xq_entry_t ok_entry(input logic [31:0] instr);
      xq_entry_t e;
      e.error = 1'b0;
      e.instr = instr;
      return e;
   endfunction

   // True when a 16-bit MIPS immediate survives truncation to signed 12 bits.
   function automatic logic fits_s12(input logic [15:0] imm);
      return (imm[15:11] == 5'b00000) || (imm[15:11] == 5'b11111);
   endfunction

   // Words that carry a delay slot and must be held back by the FSM.
   function automatic logic is_branch(input logic [31:0] word);
      mips_r_type_t r;
      r = word;
      return (r.opcode == OP_BEQ) || (r.opcode == OP_BNE) ||
             ((r.opcode == OP_SPECIAL) && (r.funct == FN_JR));
   endfunction

   // Translate one MIPS word in isolation. Anything that cannot be expressed
   // exactly comes back as an error entry with a zero instruction.
   function automatic xq_entry_t xlate_word(input logic [31:0] word,
                                            input logic [31:0] br_adj);
      mips_r_type_t r;
      mips_i_type_t i;
      logic [31:0]  off;
      xq_entry_t    e;
      r   = word;
      i   = word;
      e   = ERR_ENTRY;
      off = {{14{i.imm[15]}}, i.imm, 2'b00} - br_adj;
      case (i.opcode)
         OP_SPECIAL: begin
            case (r.funct)
               FN_ADDU: e = ok_entry({7'b0, r.rt, r.rs, 3'b000, r.rd, RV_OP});
               FN_SLTU: e = ok_entry({7'b0, r.rt, r.rs, 3'b011, r.rd, RV_OP});
               FN_OR:   e = ok_entry({7'b0, r.rt, r.rs, 3'b110, r.rd, RV_OP});
               FN_SLL:  e = ok_entry({7'b0, r.shamt, r.rt, 3'b001, r.rd, RV_OP_IMM});
               FN_JR:   e = ok_entry({12'h000, r.rs, 3'b000, 5'b00000, RV_JALR});
               default: e = ERR_ENTRY;
            endcase
         end
         OP_ADDIU: begin
            if (fits_s12(i.imm))
               e = ok_entry({i.imm[11:0], i.rs, 3'b000, i.rt, RV_OP_IMM});
         end
         OP_ORI: begin
            // MIPS zero-extends, RISC-V sign-extends: only the low 12 bits may be set.
            if (i.imm[15:12] == 4'h0)
               e = ok_entry({i.imm[11:0], i.rs, 3'b110, i.rt, RV_OP_IMM});
         end
         OP_LUI: e = ok_entry({i.imm, 4'h0, i.rt, RV_LUI});
         OP_SW: begin
            if (fits_s12(i.imm))
               e = ok_entry({i.imm[11:5], i.rt, i.rs, 3'b010, i.imm[4:0], RV_STORE});
         end
         OP_BEQ, OP_BNE: begin
            // B-type reach is signed 13 bits; upper bits must be pure sign copies.
            if ((off[31:12] == '0) || (off[31:12] == '1))
               e = ok_entry({off[12], off[10:5], i.rt, i.rs, 2'b00, i.opcode[0],
                             off[4:1], off[11], RV_BRANCH});
         end
         default: e = ERR_ENTRY;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/mips_xlate_outq.sv
// ---------------------------------------------------------------------------
// mips_xlate_outq
// Circular output queue of {error, instr} entries with up to two pushes and
// one pop per cycle. Pointers wrap modulo OUT_DEPTH (power of two).
// Ports:
//   clk, pipe_rst_n      clock, async active-low reset
//   flush                synchronous empty
//   push_cnt             number of entries pushed this cycle (0..2)
//   push_a, push_b       first / second entry pushed
//   pop                  remove head (ignored when empty)
//   head                 entry at read pointer
//   q_level              occupancy
// ---------------------------------------------------------------------------
module mips_xlate_outq
   import mips_xlate_pkg::*;
#(
   parameter int OUT_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         pipe_rst_n,
   input  logic                         flush,
   input  logic [1:0]                   push_cnt,
   input  logic [ENTRY_W-1:0]           push_a,
   input  logic [ENTRY_W-1:0]           push_b,
   input  logic                         pop,
   output logic [ENTRY_W-1:0]           head,
   output logic [$clog2(OUT_DEPTH):0]   q_level
);

   localparam int PTR_W = $clog2(OUT_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [ENTRY_W-1:0] mem [OUT_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr_nxt;
   logic               pop_ok;

   assign wr_ptr_nxt = wr_ptr + PTR_W'(1);
   assign pop_ok     = pop && (q_level != '0);
   assign head       = mem[rd_ptr];

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (!flush) begin
         if (push_cnt != 2'd0)
            mem[wr_ptr] <= push_a;
         if (push_cnt == 2'd2)
            mem[wr_ptr_nxt] <= push_b;
      end
   end

   // Pointer and occupancy bookkeeping; push and pop in one cycle both count.
   always_ff @(posedge clk or negedge pipe_rst_n) begin
      if (!pipe_rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_level <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_level <= '0;
      end else begin
         wr_ptr  <= wr_ptr + PTR_W'(push_cnt);
         if (pop_ok)
            rd_ptr <= rd_ptr + PTR_W'(1);
         q_level <= q_level + LVL_W'(push_cnt) - LVL_W'(pop_ok);
      end
   end

endmodule

// File: rtl/mips_to_riscv_xlate_q.sv
// ---------------------------------------------------------------------------
// mips_to_riscv_xlate_q
// Accepts MIPS instruction words, translates them to RISC-V and queues the
// results. Branches/JR are held until their delay slot arrives so that the
// slot is emitted first. Optional LUI+ORI fusion is enabled by defining
// MIPS_XLATE_LUI_ORI_FUSE_EN; without it LUI translates immediately.
// Ports:
//   clk, pipe_rst_n            clock, async active-low reset
//   mips_instruction/_valid/_error   input word, valid, fetch error tag
//   translator_ready           input accepted when valid && ready
//   flush                      discard all pending work
//   riscv_instruction/_valid/_error  queue head
//   riscv_instr_accepted       consumer pops head when valid && accepted
//   q_level                    queue occupancy
// ---------------------------------------------------------------------------
module mips_to_riscv_xlate_q
   import mips_xlate_pkg::*;
#(
   parameter int OUT_DEPTH = 4,
   parameter int BR_ADJ    = 4
) (
   input  logic                         clk,
   input  logic                         pipe_rst_n,
   input  logic [31:0]                  mips_instruction,
   input  logic                         mips_instr_valid,
   input  logic                         mips_instr_error,
   output logic                         translator_ready,
   input  logic                         flush,
   output logic [31:0]                  riscv_instruction,
   output logic                         riscv_instr_valid,
   output logic                         riscv_instr_error,
   input  logic                         riscv_instr_accepted,
   output logic [$clog2(OUT_DEPTH):0]   q_level
);

   localparam int          LVL_W    = $clog2(OUT_DEPTH) + 1;
   localparam logic [31:0] BR_ADJ_W = 32'(BR_ADJ);

   xlate_state_t state;
   logic [31:0]  stash_word;
   logic         run;
   logic         accept;
   logic         in_br;
   logic         stash_in;
   xq_entry_t    in_entry;
   xq_entry_t    slot_entry;
   xq_entry_t    stash_entry;
   xq_entry_t    head;
   xq_entry_t    push_a;
   xq_entry_t    push_b;
   logic [1:0]   push_cnt;
   logic         pop;

   // run holds ready low through reset and the first edge after it.
   assign translator_ready  = run && !flush && (q_level <= LVL_W'(OUT_DEPTH - 2));
   assign accept            = mips_instr_valid && translator_ready;
   assign riscv_instr_valid = (q_level != '0);
   assign riscv_instr_error = riscv_instr_valid && head.error;
   assign riscv_instruction = riscv_instr_valid ? head.instr : 32'h0;
   assign pop               = riscv_instr_valid && riscv_instr_accepted;

   // Fetch-error words never stash; they become error entries in sequence.
   assign in_br       = !mips_instr_error && is_branch(mips_instruction);
   assign in_entry    = mips_instr_error ? ERR_ENTRY : xlate_word(mips_instruction, BR_ADJ_W);
   assign slot_entry  = in_br ? ERR_ENTRY : in_entry;
   assign stash_entry = xlate_word(stash_word, BR_ADJ_W);

`ifdef MIPS_XLATE_LUI_ORI_FUSE_EN
   mips_i_type_t cur_w;
   logic         in_lui;
   logic         fuse_match;
   logic [31:0]  fuse_c;
   logic [19:0]  fuse_hi;
   xq_entry_t    fused_lui;
   xq_entry_t    fused_addi;

   // Fusion rebuilds the 32-bit constant; the +C[11] compensates for ADDI
   // sign-extending its 12-bit immediate.
   always_comb begin
      cur_w      = mips_instruction;
      in_lui     = !mips_instr_error && (cur_w.opcode == OP_LUI);
      fuse_match = !mips_instr_error && (cur_w.opcode == OP_ORI) &&
                   (cur_w.rs == stash_word[20:16]) && (cur_w.rt == stash_word[20:16]);
      fuse_c     = {stash_word[15:0], cur_w.imm};
      fuse_hi    = fuse_c[31:12] + {19'b0, fuse_c[11]};
      fused_lui  = ok_entry({fuse_hi, stash_word[20:16], RV_LUI});
      fused_addi = ok_entry({fuse_c[11:0], stash_word[20:16], 3'b000,
                             stash_word[20:16], RV_OP_IMM});
   end

   assign stash_in = in_br || in_lui;
`else
   assign stash_in = in_br;
`endif

   // Decide what the accepted word pushes this cycle.
   always_comb begin
      push_cnt = 2'd0;
      push_a   = ERR_ENTRY;
      push_b   = ERR_ENTRY;
      if (accept) begin
         case (state)
            IDLE: begin
               if (!stash_in) begin
                  push_cnt = 2'd1;
                  push_a   = in_entry;
               end
            end
            HOLD_BR: begin
               push_cnt = 2'd2;
               push_a   = slot_entry;
               push_b   = stash_entry;
            end
`ifdef MIPS_XLATE_LUI_ORI_FUSE_EN
            HOLD_LUI: begin
               if (fuse_match) begin
                  push_cnt = 2'd2;
                  push_a   = fused_lui;
                  push_b   = fused_addi;
               end else begin
                  push_a = stash_entry;
                  if (stash_in) begin
                     push_cnt = 2'd1;
                  end else begin
                     push_cnt = 2'd2;
                     push_b   = in_entry;
                  end
               end
            end
`endif
            default: push_cnt = 2'd0;
         endcase
      end
   end

   // Input FSM: stash delay-slot owners (and LUI when fusing), release them
   // with the following word. Flush and reset drop whatever is stashed.
   always_ff @(posedge clk or negedge pipe_rst_n) begin
      if (!pipe_rst_n) begin
         state      <= IDLE;
         stash_word <= '0;
         run        <= 1'b0;
      end else begin
         run <= 1'b1;
         if (flush) begin
            state <= IDLE;
         end else if (accept) begin
            case (state)
               IDLE: begin
                  if (in_br) begin
                     state      <= HOLD_BR;
                     stash_word <= mips_instruction;
                  end
`ifdef MIPS_XLATE_LUI_ORI_FUSE_EN
                  else if (in_lui) begin
                     state      <= HOLD_LUI;
                     stash_word <= mips_instruction;
                  end
`endif
               end
               HOLD_BR: state <= IDLE;
`ifdef MIPS_XLATE_LUI_ORI_FUSE_EN
               HOLD_LUI: begin
                  if (fuse_match) begin
                     state <= IDLE;
                  end else if (in_br) begin
                     state      <= HOLD_BR;
                     stash_word <= mips_instruction;
                  end else if (in_lui) begin
                     state      <= HOLD_LUI;
                     stash_word <= mips_instruction;
                  end else begin
                     state <= IDLE;
                  end
               end
`endif
               default: state <= IDLE;
            endcase
         end
      end
   end

   mips_xlate_outq #(
      .OUT_DEPTH (OUT_DEPTH)
   ) u_outq (
      .clk        (clk),
      .pipe_rst_n (pipe_rst_n),
      .flush      (flush),
      .push_cnt   (push_cnt),
      .push_a     (push_a),
      .push_b     (push_b),
      .pop        (pop),
      .head       (head),
      .q_level    (q_level)
   );

endmodule

// File: tb/tb_mips_to_riscv_xlate_q.sv
// ---------------------------------------------------------------------------
// tb_mips_to_riscv_xlate_q
// Directed, table-driven bench for mips_to_riscv_xlate_q (OUT_DEPTH=4,
// BR_ADJ=4). Fusion vectors are selected by MIPS_XLATE_LUI_ORI_FUSE_EN.
// ---------------------------------------------------------------------------
module tb_mips_to_riscv_xlate_q;

   logic        clk = 1'b0;
   logic        pipe_rst_n;
   logic [31:0] mips_instruction;
   logic        mips_instr_valid;
   logic        mips_instr_error;
   logic        translator_ready;
   logic        flush;
   logic [31:0] riscv_instruction;
   logic        riscv_instr_valid;
   logic        riscv_instr_error;
   logic        riscv_instr_accepted;
   logic [2:0]  q_level;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] word;
      logic        err_in;
      logic        exp_err;
      logic [31:0] exp_instr;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   mips_to_riscv_xlate_q #(
      .OUT_DEPTH (4),
      .BR_ADJ    (4)
   ) dut (
      .clk                  (clk),
      .pipe_rst_n           (pipe_rst_n),
      .mips_instruction     (mips_instruction),
      .mips_instr_valid     (mips_instr_valid),
      .mips_instr_error     (mips_instr_error),
      .translator_ready     (translator_ready),
      .flush                (flush),
      .riscv_instruction    (riscv_instruction),
      .riscv_instr_valid    (riscv_instr_valid),
      .riscv_instr_error    (riscv_instr_error),
      .riscv_instr_accepted (riscv_instr_accepted),
      .q_level              (q_level)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic addVec(input logic [31:0] w, input logic ei, input logic ee, input logic [31:0] ex);
      vec_t v;
      v.word = w; v.err_in = ei; v.exp_err = ee; v.exp_instr = ex;
      vecs.push_back(v);
   endtask

   // Drive one word and hold it until it is accepted on a rising edge.
   task automatic applyStimulus(input logic [31:0] word, input logic err);
      int waited = 0;
      @(negedge clk);
      while (!translator_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!translator_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL ready_timeout: word 0x%08h never accepted", word);
      end else begin
         mips_instruction = word;
         mips_instr_error = err;
         mips_instr_valid = 1'b1;
         @(posedge clk);
         #1;
         mips_instr_valid = 1'b0;
         mips_instr_error = 1'b0;
      end
   endtask

   task automatic popOne();
      @(negedge clk);
      riscv_instr_accepted = 1'b1;
      @(posedge clk);
      #1;
      riscv_instr_accepted = 1'b0;
   endtask

   task automatic expectHead(input string name, input logic err, input logic [31:0] instr);
      checkOutput({name, " valid"}, 32'(riscv_instr_valid), 32'd1);
      checkOutput({name, " error"}, 32'(riscv_instr_error), 32'(err));
      checkOutput({name, " instr"}, riscv_instruction, instr);
   endtask

   task automatic drainAll();
      int n = 0;
      while (riscv_instr_valid && n < 8) begin
         popOne();
         n++;
      end
      checkOutput("drain empty", 32'(riscv_instr_valid), 32'd0);
   endtask

   initial begin
      pipe_rst_n           = 1'b0;
      mips_instruction     = 32'h0;
      mips_instr_valid     = 1'b0;
      mips_instr_error     = 1'b0;
      flush                = 1'b0;
      riscv_instr_accepted = 1'b0;

      addVec(32'h00851021, 1'b0, 1'b0, 32'h00520133);
      addVec(32'h0085102B, 1'b0, 1'b0, 32'h00523133);
      addVec(32'h00851025, 1'b0, 1'b0, 32'h00526133);
      addVec(32'h000510C0, 1'b0, 1'b0, 32'h00329113);
      addVec(32'h24880010, 1'b0, 1'b0, 32'h01020413);
      addVec(32'h2488FFFF, 1'b0, 1'b0, 32'hFFF20413);
      addVec(32'h24880800, 1'b0, 1'b1, 32'h00000000);
      addVec(32'h2488F800, 1'b0, 1'b0, 32'h80020413);
      addVec(32'h35085678, 1'b0, 1'b1, 32'h00000000);
      addVec(32'h35080FFF, 1'b0, 1'b0, 32'hFFF46413);
      addVec(32'hAC850024, 1'b0, 1'b0, 32'h02522223);
      addVec(32'hAC851000, 1'b0, 1'b1, 32'h00000000);
      addVec(32'h08000000, 1'b0, 1'b1, 32'h00000000);
      addVec(32'h00851022, 1'b0, 1'b1, 32'h00000000);
      addVec(32'h00851021, 1'b1, 1'b1, 32'h00000000);
`ifndef MIPS_XLATE_LUI_ORI_FUSE_EN
      addVec(32'h3C081234, 1'b0, 1'b0, 32'h12340437);
`endif

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset ready", 32'(translator_ready), 32'd0);
      checkOutput("reset valid", 32'(riscv_instr_valid), 32'd0);
      checkOutput("reset error", 32'(riscv_instr_error), 32'd0);
      checkOutput("reset level", 32'(q_level), 32'd0);
      pipe_rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("post-reset ready", 32'(translator_ready), 32'd1);

      // Single-word translations
      foreach (vecs[i]) begin
         checkOutput($sformatf("vec%0d pre level", i), 32'(q_level), 32'd0);
         applyStimulus(vecs[i].word, vecs[i].err_in);
         expectHead($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_instr);
         checkOutput($sformatf("vec%0d level", i), 32'(q_level), 32'd1);
         popOne();
         checkOutput($sformatf("vec%0d popped", i), 32'(riscv_instr_valid), 32'd0);
      end

      // BEQ then ADDU in the delay slot
      applyStimulus(32'h10850003, 1'b0);
      checkOutput("beq stash level", 32'(q_level), 32'd0);
      applyStimulus(32'h00851021, 1'b0);
      checkOutput("beq pair level", 32'(q_level), 32'd2);
      expectHead("beq slot", 1'b0, 32'h00520133);
      popOne();
      expectHead("beq branch", 1'b0, 32'h00520463);
      drainAll();

      // BNE with negative offset, slot holds a branch -> error slot entry
      applyStimulus(32'h1485FFFF, 1'b0);
      applyStimulus(32'h10850003, 1'b0);
      checkOutput("bnebr level", 32'(q_level), 32'd2);
      expectHead("bnebr slot", 1'b1, 32'h00000000);
      popOne();
      expectHead("bnebr branch", 1'b0, 32'hFE521CE3);
      drainAll();

      // JR with ADDU slot
      applyStimulus(32'h03E00008, 1'b0);
      applyStimulus(32'h00851021, 1'b0);
      expectHead("jr slot", 1'b0, 32'h00520133);
      popOne();
      expectHead("jr jalr", 1'b0, 32'h000F8067);
      drainAll();

      // Branch offset out of range, plus fetch error filling a slot
      applyStimulus(32'h10850401, 1'b0);
      applyStimulus(32'h00851021, 1'b0);
      expectHead("brrange slot", 1'b0, 32'h00520133);
      popOne();
      expectHead("brrange branch", 1'b1, 32'h00000000);
      drainAll();
      applyStimulus(32'h10850003, 1'b0);
      applyStimulus(32'h00851021, 1'b1);
      expectHead("errslot slot", 1'b1, 32'h00000000);
      popOne();
      expectHead("errslot branch", 1'b0, 32'h00520463);
      drainAll();

      // Queue fill with consumer stalled
      applyStimulus(32'h00851021, 1'b0);
      applyStimulus(32'h00851025, 1'b0);
      applyStimulus(32'h0085102B, 1'b0);
      checkOutput("fill level", 32'(q_level), 32'd3);
      checkOutput("fill ready", 32'(translator_ready), 32'd0);
      popOne();
      checkOutput("fill pop ready", 32'(translator_ready), 32'd1);
      checkOutput("fill pop level", 32'(q_level), 32'd2);
      expectHead("fill head", 1'b0, 32'h00526133);
      popOne();
      expectHead("fill wrap", 1'b0, 32'h00523133);
      drainAll();

      // Flush after a stashed BEQ
      applyStimulus(32'h10850003, 1'b0);
      @(negedge clk);
      flush = 1'b1;
      #1;
      checkOutput("flush ready", 32'(translator_ready), 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      checkOutput("flush level", 32'(q_level), 32'd0);
      applyStimulus(32'h00851021, 1'b0);
      checkOutput("post-flush level", 32'(q_level), 32'd1);
      expectHead("post-flush", 1'b0, 32'h00520133);
      drainAll();

      // Flush with entries queued
      applyStimulus(32'h00851021, 1'b0);
      applyStimulus(32'h00851025, 1'b0);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checkOutput("flushq level", 32'(q_level), 32'd0);
      checkOutput("flushq valid", 32'(riscv_instr_valid), 32'd0);

      // Reset mid-operation: queued entry and stashed branch vanish
      applyStimulus(32'h00851021, 1'b0);
      applyStimulus(32'h10850003, 1'b0);
      @(negedge clk);
      pipe_rst_n = 1'b0;
      #1;
      checkOutput("midrst ready", 32'(translator_ready), 32'd0);
      checkOutput("midrst level", 32'(q_level), 32'd0);
      checkOutput("midrst valid", 32'(riscv_instr_valid), 32'd0);
      @(negedge clk);
      pipe_rst_n = 1'b1;
      applyStimulus(32'h00851021, 1'b0);
      checkOutput("post-rst level", 32'(q_level), 32'd1);
      expectHead("post-rst", 1'b0, 32'h00520133);
      drainAll();

`ifdef MIPS_XLATE_LUI_ORI_FUSE_EN
      // LUI+ORI fusion, with and without the ADDI sign carry
      applyStimulus(32'h3C081234, 1'b0);
      checkOutput("fuse1 stash level", 32'(q_level), 32'd0);
      applyStimulus(32'h35085678, 1'b0);
      expectHead("fuse1 lui", 1'b0, 32'h12345437);
      popOne();
      expectHead("fuse1 addi", 1'b0, 32'h67840413);
      drainAll();
      applyStimulus(32'h3C081234, 1'b0);
      applyStimulus(32'h35080800, 1'b0);
      expectHead("fuse2 lui", 1'b0, 32'h12341437);
      popOne();
      expectHead("fuse2 addi", 1'b0, 32'h80040413);
      drainAll();
      // Non-matching follower
      applyStimulus(32'h3C081234, 1'b0);
      applyStimulus(32'h00851021, 1'b0);
      checkOutput("nofuse level", 32'(q_level), 32'd2);
      expectHead("nofuse lui", 1'b0, 32'h12340437);
      popOne();
      expectHead("nofuse addu", 1'b0, 32'h00520133);
      drainAll();
      // LUI followed by a branch: LUI out, branch held for its slot
      applyStimulus(32'h3C081234, 1'b0);
      applyStimulus(32'h10850003, 1'b0);
      checkOutput("luibr level", 32'(q_level), 32'd1);
      applyStimulus(32'h00851021, 1'b0);
      expectHead("luibr lui", 1'b0, 32'h12340437);
      popOne();
      expectHead("luibr slot", 1'b0, 32'h00520133);
      popOne();
      expectHead("luibr branch", 1'b0, 32'h00520463);
      drainAll();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
